// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the AES key-schedule and cipher datapath blocks:
//   the forward S-box table, the GF(2^8) xtime helper, key-size constants
//   (NK/NR for AES-128 and AES-256) and the key expander state enum.
//   No ports; imported with "import aes_pkg::*;".
// ----------------------------------------------------------------------------
package aes_pkg;

    // Key-size constants: Nk = key length in 32-bit words, Nr = last round index.
    localparam int NK_128 = 4;
    localparam int NR_128 = 10;
    localparam int NK_256 = 8;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EXPAND,
        DONE
    } exp_state_t;

    // Forward AES S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nk_of(input int key_bits);
        return (key_bits == 256) ? NK_256 : NK_128;
    endfunction

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? NR_256 : NR_128;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// ----------------------------------------------------------------------------
// aes_subword
//   Combinational 4-byte S-box slice (AES SubWord). Used by the key expander
//   and usable by the cipher datapath.
//   Ports:
//     word  in  32  input word
//     sub   out 32  S-box substitution of each byte of word
// ----------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// ----------------------------------------------------------------------------
// aes_key_expander
//   Iterative AES key expansion. Accepts a 128- or 256-bit cipher key and
//   streams round keys 0..NR as 128-bit beats on a valid/ready interface,
//   producing one 32-bit schedule word per cycle.
//   Parameter:
//     KEY_BITS  128 or 256 (anything else stops elaboration)
//   Ports:
//     clk       in   1         clock, rising edge
//     rst_n     in   1         asynchronous active-low reset
//     key_in    in   KEY_BITS  cipher key, w0 in the MSBs
//     start     in   1         request expansion (ignored while busy)
//     busy      out  1         expansion in progress (through the done cycle)
//     rk_data   out  128       round key {w[4r],..,w[4r+3]}
//     rk_round  out  4         round index of rk_data
//     rk_valid  out  1         rk_data/rk_round valid
//     rk_ready  in   1         consumer accepts the beat
//     done      out  1         one-cycle pulse after the last beat
//     rd_round  in   4         cache read index  (AES_KEY_CACHE_EN only)
//     rd_data   out  128       cache read data   (AES_KEY_CACHE_EN only)
//   Build option:
//     AES_KEY_CACHE_EN  adds a 15x128 cache of every handshaken round key.
// ----------------------------------------------------------------------------
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                start,
    output logic                busy,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_round,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                done
`ifdef AES_KEY_CACHE_EN
    ,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_data
`endif
);

    localparam int         NK  = nk_of(KEY_BITS);
    localparam int         NR  = nr_of(KEY_BITS);
    localparam logic [3:0] NR4 = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expander: KEY_BITS must be 128 or 256");
    end

    exp_state_t  state;
    exp_state_t  state_nxt;

    // Sliding window of the last NK schedule words; win[0] is w[i-Nk],
    // win[NK-1] is w[i-1].
    logic [31:0] win [NK];
    logic [7:0]  rcon;
    logic [3:0]  round;
    logic [2:0]  wpos;
    logic [1:0]  cnt;

    logic [31:0] last;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;

    // Next schedule word. wpos tracks i mod Nk, so wpos==0 selects the
    // RotWord/SubWord/rcon step and wpos==4 the extra AES-256 SubWord step.
    // RotWord is applied ahead of the shared S-box so one slice serves both.
    assign last   = win[NK-1];
    assign sub_in = (wpos == 3'd0) ? {last[23:0], last[31:24]} : last;

    aes_subword u_subword (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        temp = last;
        if (wpos == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && wpos == 3'd4) begin
            temp = sub_out;
        end
    end

    assign new_word = win[0] ^ temp;

    // Round key presented from the window. For AES-256, rk0 is the first
    // half of the key and every later key is the newest four words.
    assign rk_data  = (NK == 8 && round != 4'd0) ?
                      {win[NK-4], win[NK-3], win[NK-2], win[NK-1]} :
                      {win[0], win[1], win[2], win[3]};
    assign rk_round = round;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs. AES-256 skips EXPAND between rk0 and
    // rk1 because rk1 is simply the upper key words already in the window.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        rk_valid  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (round == NR4) begin
                        state_nxt = DONE;
                    end else if (NK == 8 && round == 4'd0) begin
                        state_nxt = EMIT;
                    end else begin
                        state_nxt = EXPAND;
                    end
                end
            end
            EXPAND: begin
                if (cnt == 2'd3) begin
                    state_nxt = EMIT;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Schedule datapath: key load, round counter, and one-word-per-cycle
    // window shift with rcon advanced right after each use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NK; j++) begin
                win[j] <= '0;
            end
            rcon  <= '0;
            round <= '0;
            wpos  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int j = 0; j < NK; j++) begin
                            win[j] <= key_in[KEY_BITS-1-32*j -: 32];
                        end
                        rcon  <= 8'h01;
                        round <= 4'd0;
                        wpos  <= 3'd0;
                        cnt   <= 2'd0;
                    end
                end
                EMIT: begin
                    if (rk_ready && round != NR4) begin
                        round <= round + 4'd1;
                        cnt   <= 2'd0;
                    end
                end
                EXPAND: begin
                    for (int j = 0; j < NK - 1; j++) begin
                        win[j] <= win[j+1];
                    end
                    win[NK-1] <= new_word;
                    wpos      <= (wpos == 3'(NK - 1)) ? 3'd0 : wpos + 3'd1;
                    cnt       <= cnt + 2'd1;
                    if (wpos == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef AES_KEY_CACHE_EN
    // Round-key cache: survives new starts so earlier keys stay readable
    // until their slot is overwritten.
    logic [127:0] cache [15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 15; j++) begin
                cache[j] <= '0;
            end
        end else if (rk_valid && rk_ready) begin
            cache[rk_round] <= rk_data;
        end
    end

    assign rd_data = (rd_round > NR4) ? '0 : cache[rd_round];
`endif

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES key-expansion engine; the parametrised successor to the single-round key-schedule stage.
- Takes a 128- or 256-bit cipher key and produces every round key, 0..Nr, in order. Each key is a 128-bit beat on a valid/ready stream.
- Computes one 32-bit schedule word per cycle using a 4-byte S-box slice.
- Feeds the cipher datapath's round-key port, or a key cache ahead of it.

Parameters:
- KEY_BITS, 128, cipher key width. Legal values are 128 (Nk=4, Nr=10) and 256 (Nk=8, Nr=14); any other value is an elaboration error.
- NR, derived (10 or 14), last round index. Localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_in  in  KEY_BITS  cipher key. Big-endian: key_in[KEY_BITS-1 -: 32] is w0.
- start  in  1  request expansion; sampled only when busy=0
- busy  out  1  high from the cycle after start is accepted through the done cycle
- rk_data  out  128  round key; {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in the MSBs
- rk_round  out  4  index r of rk_data
- rk_valid  out  1  rk_data/rk_round valid
- rk_ready  in  1  consumer accepts the beat
- done  out  1  one-cycle pulse after round NR is handshaken
- rd_round  in  4  cache read index (AES_KEY_CACHE_EN builds only)
- rd_data  out  128  cache read data (AES_KEY_CACHE_EN builds only)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, rk_valid=0, done=0, rk_data=0, rk_round=0; word window, rcon and counters cleared. Reset mid-expansion aborts immediately; no partial output survives.
- States:
  - IDLE: start=1 latches key_in into an Nk-word window, sets rcon=0x01, r=0, then goes to EMIT.
  - EMIT: rk_valid=1. Holds data and round index stable until rk_ready=1.
    - On handshake with r=NR: go to DONE.
    - Else, if KEY_BITS=256 and r=0: r=1, stay in EMIT (rk1 is taken directly from the key words w4..w7).
    - Else: r=r+1, go to EXPAND.
  - EXPAND: 4 cycles, one word w[i] per cycle, then go to EMIT.
  - DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- start while busy=1 is ignored; key_in is not re-sampled.
- Word rule, with window shifting by one word per cycle: w[i]=w[i-Nk]^temp.
  - i mod Nk==0: temp=SubWord(RotWord(w[i-1]))^{rcon,24'h0}.
  - Nk=8 and i mod 8==4: temp=SubWord(w[i-1]).
  - Otherwise: temp=w[i-1].
- rcon advances after each use by xtime: 0x01..0x80, then 0x1b, then 0x36. It is never used past 0x36 (128) or 0x40 (256).
- Timing with rk_ready tied high:
  - Start accepted in cycle 0; rk0 valid in cycle 1.
  - KEY_BITS=128: rk_r valid in cycle 1+5r; rk10 in cycle 51; done in cycle 52.
  - KEY_BITS=256: rk1 in cycle 2; rk_r valid in cycle 2+5(r-1) for r>=2; rk14 in cycle 67; done in cycle 68.
- Backpressure: every extra rk_ready=0 cycle delays all later beats by one cycle. No beat is lost or duplicated.
- rk_valid never drops without a handshake, and is never asserted outside EMIT.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- Defined:
  - Each handshaken beat is written into a 15x128 register file at index rk_round.
  - rd_data = cache[rd_round], combinational; rd_round>NR returns 0.
  - Cache is cleared by rst_n and is not cleared by start, so the previous key's entries remain readable until overwritten.
- Undefined: no rd_round/rd_data ports and no storage; streaming only.

Decomposition:
- Shared package aes_pkg:
  - S-box constant table.
  - Function xtime.
  - Localparams NK/NR per key size.
  - Expander state enum (IDLE, EMIT, EXPAND, DONE).
- Sub-module aes_subword: 32-bit combinational 4-byte S-box. Also reusable by the cipher datapath.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk0 equals the key in cycle 1.
  - rk1=a0fafe1788542cb123a339392a6c7605.
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 51.
  - done in cycle 52.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk1=1f352c073b6108d72d9810a30914dff4 in cycle 2.
  - rk2=9ba354118e6925afa51a8b5f2067fcde.
  - rk14=fe4890d1e6188d0b046df344706c631e.
- Random rk_ready (~40% low) on the 128-bit vector: same 11 keys in order, no drop or duplicate, rk_data stable while stalled.
- start pulsed again mid-expansion with a different key: ignored, original sequence completes. rst_n asserted at rk5, then restart: outputs zero immediately, clean full sequence afterwards.
- AES_KEY_CACHE_EN: after done, rd_round=0..10 returns all 128-bit-vector keys; rd_round=12 returns 0.
